led_chime: RTL and testbench
============================

LED_CHIME -- requirements
Module: led_chime

Interface
REQ-001 Parameter CLK_HZ, default 1000, SHALL set clock cycles per second.
REQ-002 Parameter NUM_CH, default 2, SHALL set the number of LED channels (2..8).
REQ-003 Parameter CNT_W, default 5, SHALL set the binary blink-count width.
REQ-004 Parameter LCD_HOLD, default 10000, SHALL set the LCD_EN high time in cycles.
REQ-005 CLK1K  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-006 RSTN  input  1  SHALL be the asynchronous, active-low reset.
REQ-007 EN  input  1  SHALL be the block enable; low aborts any activity.
REQ-008 TRIG  input  1  SHALL be the start request, a level sampled for a rising edge.
REQ-009 CH_SEL  input  $clog2(NUM_CH)  SHALL select the channel to announce.
REQ-010 BCD_IN  input  NUM_CH*8  SHALL carry per-channel count as {tens[7:4], ones[3:0]}, channel 0 in the LSBs.
REQ-011 LED  output  NUM_CH  SHALL be the per-channel blink outputs.
REQ-012 BUSY  output  1  SHALL be high from start through the last OFF phase.
REQ-013 DONE  output  1  SHALL be a one-cycle pulse at sequence completion.
REQ-014 ERR  output  1  SHALL be a one-cycle pulse on a rejected start.
REQ-015 LCD_EN  output  1  SHALL be the post-sequence display enable.

Function
REQ-016 Start SHALL occur when EN=1 and TRIG is 1 this cycle and was 0 last cycle; a held-high TRIG SHALL NOT retrigger.
REQ-017 On start, the block SHALL latch CH_SEL and the count N = tens*10 + ones of the selected channel.
REQ-018 A start with CH_SEL >= NUM_CH, or with either digit > 9, SHALL pulse ERR one cycle after the edge, with no blinking and no state change.
REQ-019 If N exceeds 2^CNT_W-1, N SHALL saturate to 2^CNT_W-1.
REQ-020 FSM states SHALL be IDLE, ON, OFF, HOLD.
REQ-021 IDLE -> ON on a valid start with N>0.
REQ-021a A valid start with N=0 SHALL pulse DONE and go IDLE -> HOLD directly.
REQ-022 ON SHALL last exactly CLK_HZ/2 cycles with the latched LED bit high, then go ON -> OFF.
REQ-023 OFF SHALL last CLK_HZ - CLK_HZ/2 cycles with all LEDs low.
REQ-023a On leaving OFF, the blink counter SHALL increment; if the count equals N, the FSM SHALL pulse DONE and enter HOLD, otherwise it SHALL return to ON.
REQ-024 The first LED rising edge SHALL occur one cycle after the start edge; N complete blinks SHALL take N*CLK_HZ cycles.
REQ-025 LCD_EN SHALL be high for exactly LCD_HOLD cycles in HOLD, then HOLD -> IDLE with LCD_EN low.
REQ-026 TRIG edges during ON/OFF SHALL be ignored.
REQ-026a A valid start during HOLD SHALL drop LCD_EN in the same cycle ON is entered and restart the sequence.
REQ-027 EN=0 in any state SHALL force IDLE on the next edge, with LED, BUSY and LCD_EN low; no DONE pulse SHALL be issued.
REQ-028 BCD_IN changes after start SHALL NOT affect the running sequence.
REQ-029 Only the latched channel's LED bit SHALL ever be high.

Reset
REQ-030 While RSTN=0, the FSM SHALL be in IDLE, all counters and the TRIG history SHALL be 0, and LED, BUSY, DONE, ERR and LCD_EN SHALL be 0.
REQ-031 Reset asserted mid-sequence SHALL clear outputs immediately, without waiting for a clock edge.
REQ-031a After reset release, a TRIG already high SHALL NOT start a sequence until it falls and rises again.

Structure
REQ-032 A shared package SHALL hold the FSM state enum and the BCD digit-limit constant (9).
REQ-033 One sub-module, bcd2bin_sat, SHALL convert the 8-bit BCD input to a CNT_W-bit saturated binary value with a digit-invalid flag.
REQ-034 Phase and LCD counters SHALL be sized by $clog2 of their terminal values.

Verification
REQ-035 Default parameters, CH_SEL=1, BCD_IN ch1=0x03, TRIG edge -> LED[1] pulses exactly 3 times (500 high / 500 low), DONE at cycle 3000, then LCD_EN high 10000 cycles; LED[0] stays 0.
REQ-036 BCD 0x00 -> DONE one cycle after the edge, no LED activity, LCD_EN high 10000 cycles.
REQ-037 BCD 0x1A, or CH_SEL=2 with NUM_CH=2 -> ERR pulse, BUSY stays 0.
REQ-038 CNT_W=4, BCD 0x23 -> exactly 15 blinks; TRIG held high across completion -> no second sequence.
REQ-039 EN dropped at cycle 1700 -> LED and BUSY low next edge, no DONE; RSTN pulsed mid-ON -> outputs 0 asynchronously.
REQ-040 New TRIG edge at HOLD cycle 500 -> LCD_EN falls and a fresh sequence runs with the newly latched count.

Source files
------------

// File: rtl/led_chime_pkg.sv
// LED chime shared types and constants.
// FSM state encoding and BCD digit limit.
package led_chime_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ON,
    S_OFF,
    S_HOLD
  } state_t;

  localparam logic [3:0] BCD_MAX = 4'd9;

endpackage

// File: rtl/bcd2bin_sat.sv
// Two-digit BCD to saturated binary.
// Flags any digit above nine as invalid.
module bcd2bin_sat
  import led_chime_pkg::*;
#(
  parameter int CNT_W = 5
) (
  input  logic [7:0]       i_bcd,
  output logic [CNT_W-1:0] o_bin,
  output logic             o_bad
);

  localparam int MAXV = (1 << CNT_W) - 1;

  logic [7:0] w_full;

  // tens*10 + ones; even 15*10+15 fits in 8 bits
  assign w_full = ({4'd0, i_bcd[7:4]} * 8'd10)
                + {4'd0, i_bcd[3:0]};

  assign o_bin = (32'(w_full) > MAXV) ? CNT_W'(MAXV)
                                      : CNT_W'(w_full);

  assign o_bad = (i_bcd[7:4] > BCD_MAX) ||
                 (i_bcd[3:0] > BCD_MAX);

endmodule

// File: rtl/led_chime.sv
// LED chime: blinks one channel N times, then
// holds the LCD enable for a fixed time.
module led_chime
  import led_chime_pkg::*;
#(
  parameter int CLK_HZ   = 1000,
  parameter int NUM_CH   = 2,
  parameter int CNT_W    = 5,
  parameter int LCD_HOLD = 10000
) (
  input  logic                      CLK1K,
  input  logic                      RSTN,
  input  logic                      EN,
  input  logic                      TRIG,
  input  logic [$clog2(NUM_CH)-1:0] CH_SEL,
  input  logic [NUM_CH*8-1:0]       BCD_IN,
  output logic [NUM_CH-1:0]         LED,
  output logic                      BUSY,
  output logic                      DONE,
  output logic                      ERR,
  output logic                      LCD_EN
);

  localparam int SW    = $clog2(NUM_CH);
  localparam int ON_T  = CLK_HZ / 2;
  localparam int OFF_T = CLK_HZ - CLK_HZ / 2;
  localparam int PW    = (CLK_HZ > 2) ? $clog2(CLK_HZ) : 1;
  localparam int LW    = (LCD_HOLD > 1) ? $clog2(LCD_HOLD) : 1;

  state_t           r_state;
  state_t           w_nxt;
  logic [PW-1:0]    r_ph;
  logic [PW-1:0]    w_ph_n;
  logic [LW-1:0]    r_lcd;
  logic [LW-1:0]    w_lcd_n;
  logic [CNT_W-1:0] r_blk;
  logic [CNT_W-1:0] w_blk_n;
  logic [CNT_W-1:0] w_blk_inc;
  logic [CNT_W-1:0] r_n;
  logic [SW-1:0]    r_ch;
  logic             r_trig_q;
  logic             r_arm;
  logic             r_done;
  logic             r_err;

  logic [7:0]       w_bcd;
  logic [CNT_W-1:0] w_bin;
  logic             w_dig_bad;
  logic             w_ch_bad;
  logic             w_bad;
  logic             w_start;
  logic             w_load;
  logic             w_done;
  logic             w_err;

  // Pick the selected channel's BCD byte
  always_comb begin
    w_bcd = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (CH_SEL == SW'(i)) w_bcd = BCD_IN[i*8 +: 8];
    end
  end

  bcd2bin_sat #(
    .CNT_W (CNT_W)
  ) u_conv (
    .i_bcd (w_bcd),
    .o_bin (w_bin),
    .o_bad (w_dig_bad)
  );

  assign w_ch_bad  = (32'(CH_SEL) >= NUM_CH);
  assign w_bad     = w_ch_bad | w_dig_bad;
  // r_arm blocks a TRIG that was already high at reset release
  assign w_start   = EN & TRIG & ~r_trig_q & r_arm;
  assign w_blk_inc = r_blk + 1'b1;

  // Next state, counters and one-cycle pulses
  always_comb begin
    w_nxt   = r_state;
    w_ph_n  = r_ph;
    w_lcd_n = r_lcd;
    w_blk_n = r_blk;
    w_load  = 1'b0;
    w_done  = 1'b0;
    w_err   = 1'b0;
    if (!EN) begin
      w_nxt   = S_IDLE;
      w_ph_n  = '0;
      w_lcd_n = '0;
      w_blk_n = '0;
    end else begin
      unique case (r_state)
        S_ON: begin
          if (r_ph == PW'(ON_T - 1)) begin
            w_nxt  = S_OFF;
            w_ph_n = '0;
          end else begin
            w_ph_n = r_ph + 1'b1;
          end
        end
        S_OFF: begin
          if (r_ph == PW'(OFF_T - 1)) begin
            w_ph_n = '0;
            if (w_blk_inc == r_n) begin
              w_nxt   = S_HOLD;
              w_blk_n = '0;
              w_lcd_n = '0;
              w_done  = 1'b1;
            end else begin
              w_nxt   = S_ON;
              w_blk_n = w_blk_inc;
            end
          end else begin
            w_ph_n = r_ph + 1'b1;
          end
        end
        S_HOLD: begin
          if (r_lcd == LW'(LCD_HOLD - 1)) begin
            w_nxt   = S_IDLE;
            w_lcd_n = '0;
          end else begin
            w_lcd_n = r_lcd + 1'b1;
          end
        end
        default: ;
      endcase
      // Starts are honoured only while not blinking
      if (w_start && !(r_state == S_ON ||
                       r_state == S_OFF)) begin
        if (w_bad) begin
          w_nxt   = r_state;
          w_lcd_n = r_lcd;
          if (r_state == S_HOLD) begin
            w_nxt   = (r_lcd == LW'(LCD_HOLD - 1))
                    ? S_IDLE : S_HOLD;
            w_lcd_n = (r_lcd == LW'(LCD_HOLD - 1))
                    ? '0 : r_lcd + 1'b1;
          end
          w_err = 1'b1;
        end else begin
          w_load  = 1'b1;
          w_ph_n  = '0;
          w_blk_n = '0;
          w_lcd_n = '0;
          if (w_bin == '0) begin
            w_nxt  = S_HOLD;
            w_done = 1'b1;
          end else begin
            w_nxt  = S_ON;
          end
        end
      end
    end
  end

  // State, counters, latched request and edge history
  always_ff @(posedge CLK1K or negedge RSTN) begin
    if (!RSTN) begin
      r_state  <= S_IDLE;
      r_ph     <= '0;
      r_lcd    <= '0;
      r_blk    <= '0;
      r_n      <= '0;
      r_ch     <= '0;
      r_trig_q <= 1'b0;
      r_arm    <= 1'b0;
      r_done   <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      r_state  <= w_nxt;
      r_ph     <= w_ph_n;
      r_lcd    <= w_lcd_n;
      r_blk    <= w_blk_n;
      r_trig_q <= TRIG;
      r_arm    <= r_arm | ~TRIG;
      r_done   <= w_done;
      r_err    <= w_err;
      if (w_load) begin
        r_n  <= w_bin;
        r_ch <= CH_SEL;
      end
    end
  end

  // Only the latched channel lights, and only in ON
  always_comb begin
    LED = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      LED[i] = (r_state == S_ON) && (r_ch == SW'(i));
    end
  end

  assign BUSY   = (r_state == S_ON) || (r_state == S_OFF);
  assign LCD_EN = (r_state == S_HOLD);
  assign DONE   = r_done;
  assign ERR    = r_err;

endmodule

// File: tb/tb_led_chime.sv
// Scoreboard bench for led_chime.
// Two instances: default and a small fast variant.
module tb_led_chime;

  localparam int K_DONE = 1;
  localparam int K_ERR  = 2;
  localparam int K_LCD  = 3;
  localparam int K_ABT  = 4;

  typedef struct {
    int kind;
    int rel;
    int rises;
    int mask;
    int first;
  } ev_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rstn_a, en_a, trig_a;
  logic [0:0]  ch_a;
  logic [15:0] bcd_a;
  logic [1:0]  led_a;
  logic        busy_a, done_a, err_a, lcd_a;

  logic        rstn_b, en_b, trig_b;
  logic [1:0]  ch_b;
  logic [23:0] bcd_b;
  logic [2:0]  led_b;
  logic        busy_b, done_b, err_b, lcd_b;

  led_chime u_a (
    .CLK1K  (clk),
    .RSTN   (rstn_a),
    .EN     (en_a),
    .TRIG   (trig_a),
    .CH_SEL (ch_a),
    .BCD_IN (bcd_a),
    .LED    (led_a),
    .BUSY   (busy_a),
    .DONE   (done_a),
    .ERR    (err_a),
    .LCD_EN (lcd_a)
  );

  led_chime #(
    .CLK_HZ   (4),
    .NUM_CH   (3),
    .CNT_W    (4),
    .LCD_HOLD (6)
  ) u_b (
    .CLK1K  (clk),
    .RSTN   (rstn_b),
    .EN     (en_b),
    .TRIG   (trig_b),
    .CH_SEL (ch_b),
    .BCD_IN (bcd_b),
    .LED    (led_b),
    .BUSY   (busy_b),
    .DONE   (done_b),
    .ERR    (err_b),
    .LCD_EN (lcd_b)
  );

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  ev_t qa[$];
  ev_t qb[$];

  int  t0[2];
  int  rises[2];
  int  mask[2];
  int  first[2];
  int  hi_st[2][8];
  int  prise[2][8];
  bit  run_chk[2];

  logic [7:0] lv[2];
  logic [7:0] lp[2];
  logic       bv[2], bp[2], dv[2], xv[2], cv[2], cp[2];

  always @(posedge clk) cyc++;

  function automatic int hz(input int k);
    return (k == 0) ? 1000 : 4;
  endfunction

  function automatic ev_t mk(input int kd, input int rl,
                             input int rs, input int ms,
                             input int fs);
    ev_t e;
    e.kind  = kd;
    e.rel   = rl;
    e.rises = rs;
    e.mask  = ms;
    e.first = fs;
    return e;
  endfunction

  task automatic chk(input string nm, input logic [31:0] got,
                     input int exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", nm, got, exp);
    end
  endtask

  task automatic obs(input int k, input int kd, input int rl);
    ev_t o;
    ev_t e;
    bit  none;
    o = mk(kd, rl, rises[k], mask[k], first[k]);
    checks++;
    none = (k == 0) ? (qa.size() == 0) : (qb.size() == 0);
    if (none) begin
      failures++;
      $display("FAIL unexpected_event dut=%0d got kind=%0d rel=%0d",
               k, o.kind, o.rel);
    end else begin
      e = (k == 0) ? qa.pop_front() : qb.pop_front();
      if (o != e) begin
        failures++;
        $display({"FAIL event dut=%0d got k=%0d rel=%0d r=%0d m=%0d f=%0d",
                  " exp k=%0d rel=%0d r=%0d m=%0d f=%0d"},
                 k, o.kind, o.rel, o.rises, o.mask, o.first,
                 e.kind, e.rel, e.rises, e.mask, e.first);
      end
    end
  endtask

  // Monitor: turns DUT outputs into events and blink timing checks
  always @(negedge clk) begin
    int rel;
    lv[0] = {6'd0, led_a};
    lv[1] = {5'd0, led_b};
    bv[0] = busy_a; bv[1] = busy_b;
    dv[0] = done_a; dv[1] = done_b;
    xv[0] = err_a;  xv[1] = err_b;
    cv[0] = lcd_a;  cv[1] = lcd_b;
    for (int k = 0; k < 2; k++) begin
      rel = cyc - t0[k];
      for (int c = 0; c < 8; c++) begin
        if (lv[k][c] && !lp[k][c]) begin
          rises[k]++;
          mask[k] = mask[k] | (1 << c);
          if (first[k] < 0) first[k] = rel;
          if (prise[k][c] >= 0)
            chk("blink_period", rel - prise[k][c], hz(k));
          prise[k][c] = rel;
          hi_st[k][c] = rel;
        end
        if (!lv[k][c] && lp[k][c] && run_chk[k] &&
            hi_st[k][c] >= 0)
          chk("high_time", rel - hi_st[k][c], hz(k) / 2);
      end
      if (dv[k]) obs(k, K_DONE, rel);
      if (xv[k]) obs(k, K_ERR, rel);
      if (cp[k] && !cv[k]) obs(k, K_LCD, rel);
      if (bp[k] && !bv[k] && !dv[k]) obs(k, K_ABT, rel);
      lp[k] = lv[k];
      bp[k] = bv[k];
      cp[k] = cv[k];
    end
  end

  task automatic clr(input int k);
    t0[k]    = cyc + 1;
    rises[k] = 0;
    mask[k]  = 0;
    first[k] = -1;
    for (int c = 0; c < 8; c++) begin
      hi_st[k][c] = -1;
      prise[k][c] = -1;
    end
  endtask

  // Called just after a posedge; returns just after the start edge
  task automatic start(input int k);
    clr(k);
    if (k == 0) trig_a = 1'b1;
    else        trig_b = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    rstn_a = 1'b0; rstn_b = 1'b0;
    en_a   = 1'b1; en_b   = 1'b1;
    trig_a = 1'b1; trig_b = 1'b0;
    ch_a   = '0;   ch_b   = '0;
    bcd_a  = '0;   bcd_b  = '0;
    for (int k = 0; k < 2; k++) begin
      run_chk[k] = 1'b1;
      lp[k] = '0; bp[k] = 1'b0; cp[k] = 1'b0;
      clr(k);
    end
    tick(3);
    chk("reset_a", {led_a, busy_a, done_a, err_a, lcd_a}, 0);
    chk("reset_b", {led_b, busy_b, done_b, err_b, lcd_b}, 0);
    rstn_a = 1'b1; rstn_b = 1'b1;
    tick(5);
    chk("trig_high_at_release", {busy_a, lcd_a}, 0);
    trig_a = 1'b0;
    tick(3);

    // Small instance: 0x23 saturates to 15, TRIG held high
    ch_b  = 2'd2;
    bcd_b = 24'h23_00_00;
    qb.push_back(mk(K_DONE, 60, 15, 4, 0));
    qb.push_back(mk(K_LCD, 66, 15, 4, 0));
    start(1);
    tick(100);
    trig_b = 1'b0;
    tick(2);

    // Channel index beyond NUM_CH
    ch_b = 2'd3;
    qb.push_back(mk(K_ERR, 0, 0, 0, -1));
    start(1);
    chk("err_busy_b", busy_b, 0);
    trig_b = 1'b0;
    tick(2);

    // Nine blinks on channel 0
    ch_b  = 2'd0;
    bcd_b = 24'h00_00_09;
    qb.push_back(mk(K_DONE, 36, 9, 1, 0));
    qb.push_back(mk(K_LCD, 42, 9, 1, 0));
    start(1);
    trig_b = 1'b0;
    tick(50);

    // Three blinks on channel 1, input changed mid-run
    ch_a  = 1'b1;
    bcd_a = 16'h03_05;
    qa.push_back(mk(K_DONE, 3000, 3, 2, 0));
    qa.push_back(mk(K_LCD, 13000, 3, 2, 0));
    start(0);
    trig_a = 1'b0;
    tick(99);
    bcd_a = 16'h09_05;
    tick(13000);

    // Zero count goes straight to HOLD
    bcd_a = 16'h00_05;
    qa.push_back(mk(K_DONE, 0, 0, 0, -1));
    qa.push_back(mk(K_LCD, 10000, 0, 0, -1));
    start(0);
    trig_a = 1'b0;
    tick(10005);

    // Invalid ones digit
    bcd_a = 16'h1A_05;
    qa.push_back(mk(K_ERR, 0, 0, 0, -1));
    start(0);
    chk("err_busy_a", busy_a, 0);
    trig_a = 1'b0;
    tick(2);
    chk("err_idle_a", {busy_a, lcd_a}, 0);
    tick(2);

    // EN dropped at cycle 1700 of a five-blink run
    ch_a  = 1'b0;
    bcd_a = 16'h00_05;
    qa.push_back(mk(K_ABT, 1700, 2, 1, 0));
    start(0);
    trig_a = 1'b0;
    tick(1699);
    en_a = 1'b0;
    tick(1);
    chk("en_drop_led_busy", {led_a, busy_a}, 0);
    tick(3);
    en_a = 1'b1;
    tick(2);

    // Reset pulsed during ON
    run_chk[0] = 1'b0;
    qa.push_back(mk(K_ABT, 200, 1, 1, 0));
    start(0);
    trig_a = 1'b0;
    tick(200);
    rstn_a = 1'b0;
    #1;
    chk("async_reset", {led_a, busy_a, done_a, err_a, lcd_a}, 0);
    tick(1);
    rstn_a = 1'b1;
    tick(3);
    run_chk[0] = 1'b1;

    // Restart from HOLD with a new count
    ch_a  = 1'b1;
    bcd_a = 16'h01_05;
    qa.push_back(mk(K_DONE, 1000, 1, 2, 0));
    start(0);
    trig_a = 1'b0;
    tick(10);
    bcd_a = 16'h02_05;
    tick(1489);
    qa.push_back(mk(K_LCD, 0, 1, 2, 0));
    qa.push_back(mk(K_DONE, 2000, 2, 2, 0));
    qa.push_back(mk(K_LCD, 2100, 2, 2, 0));
    start(0);
    trig_a = 1'b0;
    tick(2099);
    en_a = 1'b0;
    tick(1);
    chk("hold_en_drop", lcd_a, 0);
    tick(3);
    en_a = 1'b1;
    tick(5);

    chk("qa_drained", qa.size(), 0);
    chk("qb_drained", qb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
